// File: rtl/d_mem_arbiter_pkg.sv
// rtl/d_mem_arbiter_pkg.sv - shared state encodings and direction codes for the data memory arbiter
package d_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_e;

    localparam logic DIRECTION_READ  = 1'b0;
    localparam logic DIRECTION_WRITE = 1'b1;

    function automatic arb_state_e grant_state(input logic port);
        return port ? ST_GRANT1 : ST_GRANT0;
    endfunction

endpackage

// File: rtl/d_mem_arbiter.sv
// rtl/d_mem_arbiter.sv - two-port round-robin arbiter in front of a single data memory
module d_mem_arbiter
    import d_mem_arbiter_pkg::*;
#(
    parameter int d_addr_width = 8'd8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s0_req,
    input  logic                    s0_dir,
    input  logic [d_addr_width-1:0] s0_addr,
    input  logic [7:0]              s0_wdata,
    output logic                    s0_ack,
    output logic [7:0]              s0_rdata,
    input  logic                    s1_req,
    input  logic                    s1_dir,
    input  logic [d_addr_width-1:0] s1_addr,
    input  logic [7:0]              s1_wdata,
    output logic                    s1_ack,
    output logic [7:0]              s1_rdata,
    output logic                    m_req,
    output logic                    m_dir,
    output logic [d_addr_width-1:0] m_addr,
    output logic [7:0]              m_wdata,
    input  logic                    m_ack,
    input  logic [7:0]              m_rdata,
    output logic [1:0]              grant
);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    logic       pick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        pick    = 1'b0;
        m_req   = 1'b0;
        m_dir   = DIRECTION_READ;
        m_addr  = '0;
        m_wdata = '0;
        grant   = 2'b00;
        s0_ack  = 1'b0;
        s1_ack  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // On a tie the port that was not served last wins.
                if (s0_req || s1_req) begin
                    pick    = (s0_req && s1_req) ? ~last_q : s1_req;
                    state_d = grant_state(pick);
                    last_d  = pick;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT0: begin
                m_req   = 1'b1;
                m_dir   = s0_dir;
                m_addr  = s0_addr;
                m_wdata = s0_wdata;
                grant   = 2'b01;
                s0_ack  = m_ack;
                if (m_ack) state_d = ST_DONE;
            end
            ST_GRANT1: begin
                m_req   = 1'b1;
                m_dir   = s1_dir;
                m_addr  = s1_addr;
                m_wdata = s1_wdata;
                grant   = 2'b10;
                s1_ack  = m_ack;
                if (m_ack) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign s0_rdata = m_rdata;
    assign s1_rdata = m_rdata;

endmodule
